// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter for the shared internal register bus.
// Each transaction runs IDLE -> ISSUE -> (WAIT_RD) -> DONE. Every output is registered.
module reg_bus_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_m0_req,
  input  logic              i_m0_wr,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  input  logic              i_m1_req,
  input  logic              i_m1_wr,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m0_ack,
  output logic              o_m1_ack,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic [1:0]        o_grant,
  input  logic [DATA_W-1:0] i_data_read_bus,
  output logic [ADDR_W-1:0] o_addr_bus,
  output logic [DATA_W-1:0] o_data_write_bus,
  output logic              o_wr_enable_bus
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_DONE} state_t;

  state_t             r_state;
  logic               r_owner;   // 0 = M0, 1 = M1
  logic               r_wr;
  logic               r_last;    // master served most recently
  logic [CNT_W-1:0]   r_cnt;
  logic               w_pick;

  // On a tie the master that was not served last wins.
  always_comb begin
    w_pick = i_m1_req;
    if (i_m0_req && i_m1_req) w_pick = ~r_last;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state          <= S_IDLE;
      r_owner          <= 1'b0;
      r_wr             <= 1'b0;
      r_last           <= 1'b1;
      r_cnt            <= '0;
      o_m0_ack         <= 1'b0;
      o_m1_ack         <= 1'b0;
      o_m0_rdata       <= '0;
      o_m1_rdata       <= '0;
      o_grant          <= 2'b00;
      o_addr_bus       <= '1;
      o_data_write_bus <= '0;
      o_wr_enable_bus  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_m0_req || i_m1_req) begin
            r_owner          <= w_pick;
            r_wr             <= w_pick ? i_m1_wr : i_m0_wr;
            o_addr_bus       <= w_pick ? i_m1_addr : i_m0_addr;
            o_data_write_bus <= w_pick ? i_m1_wdata : i_m0_wdata;
            o_wr_enable_bus  <= w_pick ? i_m1_wr : i_m0_wr;
            o_grant          <= w_pick ? 2'b10 : 2'b01;
            r_state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          o_wr_enable_bus <= 1'b0;
          if (r_wr || READ_LAT == 1) begin
            if (!r_wr) begin
              if (r_owner) o_m1_rdata <= i_data_read_bus;
              else         o_m0_rdata <= i_data_read_bus;
            end
            o_m0_ack <= ~r_owner;
            o_m1_ack <= r_owner;
            r_state  <= S_DONE;
          end else begin
            r_cnt   <= CNT_W'(READ_LAT - 1);
            r_state <= S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          r_cnt <= r_cnt - 1'b1;
          // Count reaching zero on this edge: decoder data is valid now.
          if (r_cnt == CNT_W'(1)) begin
            if (r_owner) o_m1_rdata <= i_data_read_bus;
            else         o_m0_rdata <= i_data_read_bus;
            o_m0_ack <= ~r_owner;
            o_m1_ack <= r_owner;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          o_m0_ack   <= 1'b0;
          o_m1_ack   <= 1'b0;
          r_last     <= r_owner;
          o_grant    <= 2'b00;
          o_addr_bus <= '1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Randomised scoreboard bench for reg_bus_arbiter with a latency-2 decoder model.
module tb_reg_bus_arbiter;
  localparam int RL = 2;

  typedef struct packed {logic wr; logic [7:0] a; logic [7:0] d;} txn_t;

  logic       clk, rst_n;
  logic [1:0] req, wr;
  logic [7:0] addr [2];
  logic [7:0] wdata [2];
  logic       m0_ack, m1_ack;
  logic [7:0] m0_rdata, m1_rdata;
  logic [1:0] grant;
  logic [7:0] rd_bus, addr_bus, dw_bus, addr_d;
  logic       we;

  int n_vec = 0, n_err = 0;
  txn_t q0[$], q1[$];

  reg_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(RL)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_req(req[0]), .i_m0_wr(wr[0]), .i_m0_addr(addr[0]), .i_m0_wdata(wdata[0]),
    .i_m1_req(req[1]), .i_m1_wr(wr[1]), .i_m1_addr(addr[1]), .i_m1_wdata(wdata[1]),
    .o_m0_ack(m0_ack), .o_m1_ack(m1_ack), .o_m0_rdata(m0_rdata), .o_m1_rdata(m1_rdata),
    .o_grant(grant), .i_data_read_bus(rd_bus), .o_addr_bus(addr_bus),
    .o_data_write_bus(dw_bus), .o_wr_enable_bus(we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rdf(input logic [7:0] a);
    return a ^ 8'h39;
  endfunction

  // Decoder: data for an address appears one cycle after the address is on the bus.
  always @(posedge clk) addr_d <= addr_bus;
  assign rd_bus = rdf(addr_d);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  int         cyc = 0, last = 1, m, lat;
  bit         nxt_valid = 0;
  logic [1:0] nxt_g, r;
  logic [7:0] exrd [2];
  txn_t       t;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_grant", grant, 0);
      chk("rst_ack", {m1_ack, m0_ack}, 0);
      chk("rst_addr", addr_bus, 8'hFF);
      chk("rst_wdata", dw_bus, 0);
      chk("rst_we", we, 0);
      chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
      last = 1; cyc = 0; nxt_valid = 0; exrd[0] = 0; exrd[1] = 0;
    end else begin
      if (nxt_valid) chk("grant", grant, nxt_g);
      nxt_valid = 0;
      if (grant == 2'b00) begin
        chk("idle_addr", addr_bus, 8'hFF);
        chk("idle_we", we, 0);
        chk("idle_ack", {m1_ack, m0_ack}, 0);
        cyc = 0;
        r = req;
        nxt_g = (r == 2'b11) ? ((last == 0) ? 2'b10 : 2'b01) : r;
        nxt_valid = 1;
      end else begin
        cyc++;
        m = int'(grant[1]);
        chk("onehot", $onehot(grant), 1);
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
          chk("q_empty", grant, 0);
        end else begin
          t = (m == 0) ? q0[0] : q1[0];
          lat = t.wr ? 2 : 1 + RL;
          chk("addr", addr_bus, t.a);
          chk("we", we, (t.wr && cyc == 1));
          if (we) chk("wdata", dw_bus, t.d);
          chk("ack", {m1_ack, m0_ack}, (cyc == lat) ? grant : 2'b00);
          if (cyc > lat) chk("overrun", cyc, lat);
          if (cyc == lat) begin
            if (!t.wr) exrd[m] = rdf(t.a);
            if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            last = m; nxt_g = 2'b00; nxt_valid = 1;
          end
        end
      end
      chk("rdata0", m0_rdata, exrd[0]);
      chk("rdata1", m1_rdata, exrd[1]);
    end
  end

  // One master transaction; entered and left at posedge+#1.
  task automatic txn(input int mi, input bit w, input logic [7:0] a, input logic [7:0] d,
                     input bit drop, input bit keep);
    int n = 0;
    bit got = 0, dropped = 0;
    req[mi] = 1'b1; wr[mi] = w; addr[mi] = a; wdata[mi] = d;
    if (mi == 0) q0.push_back({w, a, d}); else q1.push_back({w, a, d});
    while (!got && n < 60) begin
      @(posedge clk); #1; n++;
      if (drop && !dropped && grant[mi]) begin req[mi] = 1'b0; dropped = 1; end
      if ((mi == 0) ? m0_ack : m1_ack) got = 1;
    end
    if (!got) chk("ack_timeout", n, 0);
    if (!keep) req[mi] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req = 0; wr = 0; addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("async_rst_addr", addr_bus, 8'hFF);
    chk("async_rst_grant", grant, 0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single write, then latency-2 read returning 0x3C
    txn(0, 1'b1, 8'h12, 8'hA5, 0, 0);
    idle(2);
    txn(1, 1'b0, 8'h05, 8'h00, 0, 0);
    chk("t2_rdata", m1_rdata, 8'h3C);
    idle(2);

    // Ties twice
    repeat (2) begin
      fork
        txn(0, 1'b1, 8'h20, 8'h11, 0, 0);
        txn(1, 1'b1, 8'h21, 8'h22, 0, 0);
      join
      idle(1);
    end
    idle(2);

    // Both held continuously: M0 writes, M1 reads
    fork
      begin
        for (int i = 0; i < 4; i++)
          txn(0, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, i < 3);
      end
      begin
        for (int j = 0; j < 4; j++)
          txn(1, 1'b0, 8'($urandom_range(0, 255)), 8'h00, 0, j < 3);
      end
    join
    idle(2);

    // Reset during WAIT_RD; request stays high and completes after release
    fork
      txn(1, 1'b0, 8'h44, 8'h00, 0, 0);
      begin
        for (int k = 0; k < 20 && !grant[1]; k++) begin @(posedge clk); #1; end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t5_grant", grant, 0);
        chk("t5_ack", {m1_ack, m0_ack}, 0);
        chk("t5_addr", addr_bus, 8'hFF);
        chk("t5_we", we, 0);
        chk("t5_rdata1", m1_rdata, 0);
        idle(2);
        rst_n = 1'b1;
      end
    join
    idle(2);

    // M0 read to populate rdata0, then M1 drops req in ISSUE
    txn(0, 1'b0, 8'h77, 8'h00, 0, 0);
    idle(1);
    txn(1, 1'b0, 8'h66, 8'h00, 1, 0);
    chk("t6_rdata1", m1_rdata, rdf(8'h66));
    chk("t6_rdata0", m0_rdata, rdf(8'h77));
    idle(2);

    // Random traffic
    for (int rr = 0; rr < 6; rr++) begin
      fork
        begin
          for (int k0 = 0; k0 < 8; k0++) begin
            idle($urandom_range(0, 3));
            txn(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0, 0);
          end
        end
        begin
          for (int k1 = 0; k1 < 8; k1++) begin
            idle($urandom_range(0, 3));
            txn(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0, 0);
          end
        end
      join
    end
    idle(4);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
